pll_lock_ctrl: RTL and testbench



---
 rtl/pll_ctrl_pkg.sv | 28 ++
 rtl/pll_lock_ctrl_sync_bit.sv | 33 +++
 rtl/pll_lock_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL lock controller.
//   - FSM state encodings (2-bit)
//   - RELOCK_CNT_W: width of the saturating relock counter
//   - cnt_width(): counter width sized for the largest of three cycle counts
package pll_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RESET_PLL = 2'd0;
  localparam state_t ST_WAIT_LOCK = 2'd1;
  localparam state_t ST_STABLE    = 2'd2;
  localparam state_t ST_RUN       = 2'd3;

  localparam int RELOCK_CNT_W = 8;

  // clog2 of the largest count, never narrower than one bit
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pll_lock_ctrl_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears all stages to 0
//   d_i  - asynchronous input bit
//   q_o  - synchronised output (d_i after STAGES flops)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bit: STAGES must be >= 2");
  end

  logic [STAGES-1:0] sync_q;

  // shift the input through the synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL supervisor running on the free-running reference clock.
// Pulses the PLL reset, qualifies the synchronised locked flag for a
// programmable stable time, and holds the system reset until then.
// Re-arms the PLL on lock loss, lock timeout, or a software request.
// Ports:
//   clk            - free-running reference clock (not a PLL output)
//   rst            - asynchronous active-high reset
//   pll_locked_i   - PLL locked flag, asynchronous to clk
//   force_relock_i - request to re-reset the PLL, honoured only in RUN
//   pll_rst_o      - active-high PLL reset
//   sys_rst_o      - active-high system reset, low only in RUN
//   ready_o        - high only in RUN
//   timeout_err_o  - sticky lock-timeout flag
//   relock_count_o - saturating count of RUN exits
import pll_ctrl_pkg::*;

module pll_lock_ctrl #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 50000,
  parameter int LOCK_STABLE      = 1024,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_locked_i,
  input  logic                    force_relock_i,
  output logic                    pll_rst_o,
  output logic                    sys_rst_o,
  output logic                    ready_o,
  output logic                    timeout_err_o,
  output logic [RELOCK_CNT_W-1:0] relock_count_o
);

  if (RST_PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("pll_lock_ctrl: RST_PULSE_CYCLES must be >= 1");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_timeout
    $error("pll_lock_ctrl: LOCK_TIMEOUT must be >= 1");
  end
  if (LOCK_STABLE < 1) begin : g_bad_stable
    $error("pll_lock_ctrl: LOCK_STABLE must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pll_lock_ctrl: SYNC_STAGES must be >= 2");
  end

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);

  localparam logic [RELOCK_CNT_W-1:0] RELOCK_ONE = RELOCK_CNT_W'(1);
  localparam logic [RELOCK_CNT_W-1:0] RELOCK_MAX = {RELOCK_CNT_W{1'b1}};

  logic                    locked_s;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [RELOCK_CNT_W-1:0] relock_q, relock_d;
  logic                    pll_rst_q, sys_rst_q, ready_q;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_locked_i),
    .q_o (locked_s)
  );

  // next-state, counter and status computation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q;
    relock_d      = relock_q;
    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_LOCK: begin
        // lock seen wins over a timeout on the same cycle
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = ST_RESET_PLL;
          cnt_d         = CNT_ZERO;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STABLE: begin
        // a glitch restarts qualification without re-pulsing the PLL
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        cnt_d = CNT_ZERO;
        // lock loss and a request together still count as one exit
        if (!locked_s || force_relock_i) begin
          state_d = ST_RESET_PLL;
          if (relock_q != RELOCK_MAX) begin
            relock_d = relock_q + RELOCK_ONE;
          end else begin
            relock_d = relock_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // state, counter and registered outputs decoded from next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RESET_PLL;
      cnt_q         <= CNT_ZERO;
      timeout_err_q <= 1'b0;
      relock_q      <= {RELOCK_CNT_W{1'b0}};
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
      relock_q      <= relock_d;
      pll_rst_q     <= (state_d == ST_RESET_PLL);
      sys_rst_q     <= (state_d != ST_RUN);
      ready_q       <= (state_d == ST_RUN);
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign sys_rst_o      = sys_rst_q;
  assign ready_o        = ready_q;
  assign timeout_err_o  = timeout_err_q;
  assign relock_count_o = relock_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
module tb_pll_lock_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       timeout_err;
  logic [7:0] relock_count;

  int n_tests;
  int n_fail;

  pll_lock_ctrl #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT    (100),
    .LOCK_STABLE     (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_locked_i   (pll_locked),
    .force_relock_i (force_relock),
    .pll_rst_o      (pll_rst),
    .sys_rst_o      (sys_rst),
    .ready_o        (ready),
    .timeout_err_o  (timeout_err),
    .relock_count_o (relock_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       locked;
    logic       frc;
    int         ncyc;
    logic       e_pll_rst;
    logic       e_sys_rst;
    logic       e_ready;
    logic       e_terr;
    logic [7:0] e_rcnt;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input int idx, input logic e_prst, input logic e_srst,
                         input logic e_rdy, input logic e_terr, input logic [7:0] e_rcnt);
    chk({name, "_pll_rst"}, idx, {7'd0, pll_rst}, {7'd0, e_prst});
    chk({name, "_sys_rst"}, idx, {7'd0, sys_rst}, {7'd0, e_srst});
    chk({name, "_ready"},   idx, {7'd0, ready},   {7'd0, e_rdy});
    chk({name, "_terr"},    idx, {7'd0, timeout_err}, {7'd0, e_terr});
    chk({name, "_rcnt"},    idx, relock_count, e_rcnt);
  endtask

  // step n edges checking sys_rst after each one
  task automatic run_sysrst(input string name, input int n, input logic exp);
    for (int k = 0; k < n; k++) begin
      step(1);
      chk(name, k, {7'd0, sys_rst}, {7'd0, exp});
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;

    //          rst   lock  frc   n   prst  srst  rdy   terr  rcnt
    vecs[0]  = '{1'b1, 1'b0, 1'b0,  2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0,  5, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[12] = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[15] = '{1'b0, 1'b0, 1'b1,  4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[16] = '{1'b0, 1'b0, 1'b1,  5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 94, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
    vecs[18] = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[19] = '{1'b0, 1'b0, 1'b0,  3, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[20] = '{1'b0, 1'b0, 1'b0,  1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 99, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[22] = '{1'b0, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
    vecs[23] = '{1'b0, 1'b0, 1'b0,  4, 1'b0, 1'b1, 1'b0, 1'b1, 8'd2};

    // nominal lock, lock loss in RUN, same-cycle relock, WAIT_LOCK request, no lock
    for (int i = 0; i < 24; i++) begin
      rst          = vecs[i].rst;
      pll_locked   = vecs[i].locked;
      force_relock = vecs[i].frc;
      step(vecs[i].ncyc);
      chk_all("vec", i, vecs[i].e_pll_rst, vecs[i].e_sys_rst, vecs[i].e_ready,
              vecs[i].e_terr, vecs[i].e_rcnt);
    end

    // glitch during qualification
    rst          = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    step(2);
    chk_all("glitch_rst", 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    step(4);
    chk("glitch_wait_prst", 0, {7'd0, pll_rst}, 8'd0);
    pll_locked = 1'b1;
    run_sysrst("glitch_enter", 3, 1'b1);
    run_sysrst("glitch_stable5", 5, 1'b1);
    pll_locked = 1'b0;
    run_sysrst("glitch_low", 3, 1'b1);
    pll_locked = 1'b1;
    run_sysrst("glitch_requal", 10, 1'b1);
    step(1);
    chk_all("glitch_run", 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // asynchronous reset mid-STABLE
    force_relock = 1'b1;
    step(1);
    force_relock = 1'b0;
    chk_all("arst_pre", 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
    step(4);
    step(1);
    step(3);
    chk_all("arst_stable", 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
    #3;
    rst = 1'b1;
    #1;
    chk_all("arst_now", 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1);
    chk_all("arst_hold", 0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    step(3);
    chk("arst_pulse", 0, {7'd0, pll_rst}, 8'd1);
    step(1);
    chk("arst_pulse_end", 0, {7'd0, pll_rst}, 8'd0);
    step(8);
    chk("arst_not_ready", 0, {7'd0, ready}, 8'd0);
    step(1);
    chk_all("arst_run", 0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

    // 300 forced relocks, counter saturates at 255
    for (int i = 1; i <= 300; i++) begin
      int k;
      force_relock = 1'b1;
      step(1);
      force_relock = 1'b0;
      chk("sat_exit", i, {7'd0, ready}, 8'd0);
      k = 0;
      while (!ready && k < 40) begin
        step(1);
        k++;
      end
      chk("sat_ready", i, {7'd0, ready}, 8'd1);
      chk("sat_rcnt", i, relock_count, (i > 255) ? 8'd255 : 8'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
